veririsc_controller: RTL and testbench



---
 rtl/veririsc_controller.sv | 157 +++++++++++++++
 tb/tb_veririsc_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/veririsc_controller.sv
// veririsc_controller: eight-phase instruction sequencer for the VeriRISC CPU.
// Walks a free-running phase counter through fetch and execute. It decodes the
// live opcode and the accumulator zero flag into memory and datapath strobes.
// A decoded HLT freezes the machine in phase OP_ADDR until rst_n is asserted.
//
// Ports:
//   clk     in   rising-edge clock shared with memory
//   rst_n   in   asynchronous active-low reset
//   opcode  in 3 instruction opcode from the IR
//   zero    in   accumulator == 0 flag
//   phase   out 3 current phase (debug/trace)
//   sel     out  address mux select: 1 = PC, 0 = IR operand field
//   rd, wr  out  memory read / write enables
//   ld_ir, inc_pc, ld_pc, ld_ac, data_e  out  datapath strobes
//   halt    out  CPU halted (sticky)
// Outputs are a combinational decode of registered state, so an asserted reset
// takes them to their reset values immediately, without waiting for clk.
module veririsc_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       data_e,
   output logic       halt
);

   localparam int unsigned NPHASE = 8;
   localparam int unsigned PW     = $clog2(NPHASE);

   typedef enum logic [PW-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   phase_t state;
   phase_t state_next;
   logic   halted;
   logic   halted_next;

   logic is_hlt;
   logic is_skz;
   logic is_aluop;
   logic is_sto;
   logic is_jmp;

   // Opcode classes
   always_comb begin
      is_hlt   = (opcode == OP_HLT);
      is_skz   = (opcode == OP_SKZ);
      is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
      is_sto   = (opcode == OP_STO);
      is_jmp   = (opcode == OP_JMP);
   end

   // Phase counter and sticky halt flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= INST_ADDR;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         halted <= halted_next;
      end
   end

   // Next phase and per-phase control decode
   always_comb begin
      state_next  = phase_t'(PW'(state + 1'b1));
      halted_next = halted;
      phase       = state;
      sel         = 1'b0;
      rd          = 1'b0;
      wr          = 1'b0;
      ld_ir       = 1'b0;
      inc_pc      = 1'b0;
      ld_pc       = 1'b0;
      ld_ac       = 1'b0;
      data_e      = 1'b0;
      halt        = 1'b0;

      if (halted) begin
         // Frozen: hold phase OP_ADDR with every strobe quiet
         state_next = OP_ADDR;
         halt       = 1'b1;
      end else begin
         case (state)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               if (is_hlt) begin
                  state_next  = OP_ADDR;
                  halted_next = 1'b1;
                  halt        = 1'b1;
               end else begin
                  inc_pc = 1'b1;
               end
            end
            OP_FETCH: begin
               rd = is_aluop;
            end
            ALU_OP: begin
               rd     = is_aluop;
               ld_ac  = is_aluop;
               ld_pc  = is_jmp;
               data_e = is_sto;
               // Second increment makes SKZ skip the next instruction
               inc_pc = is_skz & zero;
            end
            STORE: begin
               rd     = is_aluop;
               ld_ac  = is_aluop;
               ld_pc  = is_jmp;
               data_e = is_sto;
               wr     = is_sto;
            end
            default: begin
               sel = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_veririsc_controller.sv
// tb_veririsc_controller: table-driven check of the VeriRISC phase sequencer,
// plus hand-written sequences for halt and asynchronous reset during a store.
// Output vector order: {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}.
module tb_veririsc_controller;

   logic       clk;
   logic       rst_n;
   logic [2:0] opcode;
   logic       zero;
   logic [2:0] phase;
   logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0] opc;
      logic       z;
      logic [2:0] ph;
      logic [8:0] exp;
   } vec_t;

   vec_t vq[$];

   veririsc_controller dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .opcode (opcode),
      .zero   (zero),
      .phase  (phase),
      .sel    (sel),
      .rd     (rd),
      .wr     (wr),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .data_e (data_e),
      .halt   (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] outs();
      return {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};
   endfunction

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b need %b (phase=%0d)", name, got, exp, phase);
      end
   endtask

   task automatic add(input logic [2:0] opc, input logic z, input logic [2:0] ph,
                      input logic [8:0] exp);
      vq.push_back('{opc, z, ph, exp});
   endtask

   // Fetch phases 0-3; opc for phases 0-2 may be any value
   task automatic add_fetch(input logic [2:0] early_opc, input logic [2:0] opc, input logic z);
      add(early_opc, z, 3'd0, 9'b100000000);
      add(early_opc, z, 3'd1, 9'b110000000);
      add(early_opc, z, 3'd2, 9'b110100000);
      add(opc,       z, 3'd3, 9'b110100000);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      opcode = 3'd2;
      zero   = 1'b0;

      // ADD
      add_fetch(3'd2, 3'd2, 1'b0);
      add(3'd2, 1'b0, 3'd4, 9'b000010000);
      add(3'd2, 1'b0, 3'd5, 9'b010000000);
      add(3'd2, 1'b0, 3'd6, 9'b010000100);
      add(3'd2, 1'b0, 3'd7, 9'b010000100);
      // STO, with a junk HLT opcode during early fetch
      add_fetch(3'd0, 3'd6, 1'b0);
      add(3'd6, 1'b0, 3'd4, 9'b000010000);
      add(3'd6, 1'b0, 3'd5, 9'b000000000);
      add(3'd6, 1'b0, 3'd6, 9'b000000010);
      add(3'd6, 1'b0, 3'd7, 9'b001000010);
      // SKZ, zero=1
      add_fetch(3'd1, 3'd1, 1'b1);
      add(3'd1, 1'b1, 3'd4, 9'b000010000);
      add(3'd1, 1'b1, 3'd5, 9'b000000000);
      add(3'd1, 1'b1, 3'd6, 9'b000010000);
      add(3'd1, 1'b1, 3'd7, 9'b000000000);
      // SKZ, zero=0
      add_fetch(3'd1, 3'd1, 1'b0);
      add(3'd1, 1'b0, 3'd4, 9'b000010000);
      add(3'd1, 1'b0, 3'd5, 9'b000000000);
      add(3'd1, 1'b0, 3'd6, 9'b000000000);
      add(3'd1, 1'b0, 3'd7, 9'b000000000);
      // JMP
      add_fetch(3'd7, 3'd7, 1'b0);
      add(3'd7, 1'b0, 3'd4, 9'b000010000);
      add(3'd7, 1'b0, 3'd5, 9'b000000000);
      add(3'd7, 1'b0, 3'd6, 9'b000001000);
      add(3'd7, 1'b0, 3'd7, 9'b000001000);

      // Reset state
      #2;
      check("reset_outs", outs(), 9'b100000000);
      check("reset_phase", 9'(phase), 9'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Table: one vector per cycle, checked mid-low-phase
      foreach (vq[i]) begin
         opcode = vq[i].opc;
         zero   = vq[i].z;
         #1;
         check($sformatf("vec%0d_phase", i), 9'(phase), 9'(vq[i].ph));
         check($sformatf("vec%0d_outs", i), outs(), vq[i].exp);
         check($sformatf("vec%0d_inv", i),
               9'({rd & wr, rd & data_e, ld_pc & ld_ac}), 9'd0);
         @(negedge clk);
      end

      // HLT: table ended at phase 7, so now at phase 0
      opcode = 3'd0;
      zero   = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("hlt_p4_phase", 9'(phase), 9'd4);
      check("hlt_p4_outs", outs(), 9'b000000001);
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         opcode = 3'(c);
         zero   = c[0];
         #1;
         check($sformatf("halted%0d_phase", c), 9'(phase), 9'd4);
         check($sformatf("halted%0d_outs", c), outs(), 9'b000000001);
      end
      #1;
      rst_n = 1'b0;
      #1;
      check("hlt_rst_phase", 9'(phase), 9'd0);
      check("hlt_rst_outs", outs(), 9'b100000000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("hlt_release_phase", 9'(phase), 9'd0);
      @(negedge clk);
      #1;
      check("hlt_release_p1", 9'(phase), 9'd1);

      // Async reset during STO phase 7
      do_reset();
      opcode = 3'd6;
      zero   = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      check("sto_p7_outs", outs(), 9'b001000010);
      #1;
      rst_n = 1'b0;
      #1;
      check("sto_async_outs", outs(), 9'b100000000);
      check("sto_async_phase", 9'(phase), 9'd0);
      @(negedge clk);
      #1;
      check("sto_held_outs", outs(), 9'b100000000);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("sto_restart_p1", 9'(phase), 9'd1);
      check("sto_restart_outs", outs(), 9'b110000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
